sample_feeder: RTL and testbench

- Stream source that drives the sliding-window averager's 16-bit sample input.
- On a start command it reads `length` consecutive samples from an external synchronous sample memory and presents one per cycle on `sample`/`sample_valid`.
- Honours a consumer back-pressure signal (`stall`) through a 1-entry skid buffer.
- Flags when the first WIN samples (one full averaging window) have been delivered, and pulses `done` at end of stream.

---
 rtl/sample_feeder.sv | 189 ++++++++++++++++++
 tb/tb_sample_feeder.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sample_feeder.sv
// Streams `length` samples from a synchronous sample memory (one-cycle read
// latency) to the window averager. One read is in flight at most, and a
// one-entry skid buffer absorbs it when the consumer stalls.
//
// state | meaning
// IDLE  | waiting for start; a zero-length start only pulses done
// RUN   | issuing reads while issued < length
// FLUSH | all reads issued; draining returned data to the consumer
module sample_feeder #(
    parameter int DW  = 16,
    parameter int AW  = 10,
    parameter int WIN = 12
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [AW-1:0] length,
    output logic          mem_rd,
    output logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_data,
    input  logic          stall,
    output logic [DW-1:0] sample,
    output logic          sample_valid,
    output logic          prime_done,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam logic [AW:0] ONE     = (AW+1)'(1);
    localparam logic [AW:0] WIN_CNT = (AW+1)'(WIN);

    state_t        state_q, state_d;
    logic [AW-1:0] base_q, base_d;
    logic [AW-1:0] len_q, len_d;
    logic [AW:0]   issued_q, issued_d;
    logic [AW:0]   sent_q, sent_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic          rd_pend_q, rd_pend_d;
    logic [DW-1:0] sample_q, sample_d;
    logic          valid_q, valid_d;
    logic [DW-1:0] skid_q, skid_d;
    logic          skid_valid_q, skid_valid_d;
    logic          prime_q, prime_d;
    logic          done_q, done_d;

    logic          mem_rd_c;
    logic          xfer;
    logic          out_free;
    logic [AW:0]   len_ext;

    // State and datapath registers; reset abandons any stream and in-flight read.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            base_q       <= '0;
            len_q        <= '0;
            issued_q     <= '0;
            sent_q       <= '0;
            mem_addr_q   <= '0;
            rd_pend_q    <= 1'b0;
            sample_q     <= '0;
            valid_q      <= 1'b0;
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
            prime_q      <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            len_q        <= len_d;
            issued_q     <= issued_d;
            sent_q       <= sent_d;
            mem_addr_q   <= mem_addr_d;
            rd_pend_q    <= rd_pend_d;
            sample_q     <= sample_d;
            valid_q      <= valid_d;
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
            prime_q      <= prime_d;
            done_q       <= done_d;
        end
    end

    // Next-state, read issue, return-path steering and counters.
    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        len_d        = len_q;
        issued_d     = issued_q;
        sent_d       = sent_q;
        mem_addr_d   = mem_addr_q;
        sample_d     = sample_q;
        valid_d      = valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        prime_d      = prime_q;
        done_d       = 1'b0;
        mem_rd_c     = 1'b0;

        len_ext  = {1'b0, len_q};
        xfer     = valid_q & ~stall;
        out_free = ~valid_q | xfer;

        // Older skid data always reaches the output before newer read data.
        // A read is only issued with the skid empty and stall low, so the
        // skid is never full while data returns to a blocked output stage.
        if (skid_valid_q) begin
            if (out_free) begin
                sample_d     = skid_q;
                valid_d      = 1'b1;
                skid_valid_d = rd_pend_q;
                if (rd_pend_q) begin
                    skid_d = mem_data;
                end
            end
        end else if (rd_pend_q) begin
            if (out_free) begin
                sample_d = mem_data;
                valid_d  = 1'b1;
            end else begin
                skid_d       = mem_data;
                skid_valid_d = 1'b1;
            end
        end else if (xfer) begin
            valid_d = 1'b0;
        end

        if (xfer) begin
            sent_d = sent_q + ONE;
            if (sent_d == WIN_CNT) begin
                prime_d = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    prime_d  = 1'b0;
                    issued_d = '0;
                    sent_d   = '0;
                    if (length != '0) begin
                        base_d  = base_addr;
                        len_d   = length;
                        state_d = RUN;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if ((issued_q != len_ext) && !stall && !skid_valid_q) begin
                    mem_rd_c   = 1'b1;
                    mem_addr_d = base_q + issued_q[AW-1:0];
                    issued_d   = issued_q + ONE;
                end
                if (issued_d == len_ext) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (xfer && (sent_d == len_ext)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        rd_pend_d = mem_rd_c;
    end

    assign mem_rd       = mem_rd_c;
    assign mem_addr     = mem_addr_d;
    assign sample       = sample_q;
    assign sample_valid = valid_q;
    assign prime_done   = prime_q;
    assign busy         = (state_q != IDLE);
    assign done         = done_q;

endmodule

// File: tb/tb_sample_feeder.sv
// Bench for sample_feeder: synchronous memory model, scoreboard of expected
// samples filled at start, and a negedge monitor that pops on each transfer.
module tb_sample_feeder;

    localparam int DW  = 16;
    localparam int AW  = 10;
    localparam int WIN = 12;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          stall = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW-1:0] length = '0;
    logic          mem_rd;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
    logic [DW-1:0] sample;
    logic          sample_valid;
    logic          prime_done;
    logic          busy;
    logic          done;

    logic [DW-1:0] mem [0:1023];
    logic [DW-1:0] mem_q = '0;
    logic [DW-1:0] sb [$];

    int checks = 0;
    int errors = 0;

    logic          hold_pend = 1'b0;
    logic [DW-1:0] hold_val = '0;
    logic [DW-1:0] exp_s;

    sample_feeder #(.DW(DW), .AW(AW), .WIN(WIN)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .base_addr    (base_addr),
        .length       (length),
        .mem_rd       (mem_rd),
        .mem_addr     (mem_addr),
        .mem_data     (mem_data),
        .stall        (stall),
        .sample       (sample),
        .sample_valid (sample_valid),
        .prime_done   (prime_done),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_rd) mem_q <= mem[mem_addr];
    end
    assign mem_data = mem_q;

    // Scoreboard monitor: every transfer pops one expected sample; a stalled
    // valid output must be unchanged in the following cycle.
    always @(negedge clk) begin
        if (!reset) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) begin
                checks++;
                if (sample_valid !== 1'b1 || sample !== hold_val) begin
                    errors++;
                    $display("FAIL stall_hold got valid=%b sample=%h exp valid=1 sample=%h",
                             sample_valid, sample, hold_val);
                end
            end
            if (sample_valid === 1'b1 && stall === 1'b0) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_extra got sample=%h exp no transfer", sample);
                end else begin
                    exp_s = sb.pop_front();
                    if (sample !== exp_s) begin
                        errors++;
                        $display("FAIL sb_data got %h exp %h", sample, exp_s);
                    end
                end
            end
            hold_pend = (sample_valid === 1'b1) && (stall === 1'b1);
            hold_val  = sample;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Drive start for one cycle; returns in cycle 1 of the stream.
    task automatic launch(input logic [AW-1:0] b, input logic [AW-1:0] l);
        logic [AW-1:0] a;
        start = 1'b1;
        base_addr = b;
        length = l;
        for (int i = 0; i < int'(l); i++) begin
            a = b + AW'(i);
            sb.push_back(mem[a]);
        end
        cyc();
        start = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({mem_rd, mem_addr, sample, sample_valid, prime_done, busy, done} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got rd=%b addr=%h s=%h v=%b p=%b b=%b d=%b exp all 0",
                     mem_rd, mem_addr, sample, sample_valid, prime_done, busy, done);
        end
        reset = 1'b1;
        cyc();
    endtask

    task automatic test_basic();
        mem[100] = 16'hA0A0; mem[101] = 16'hA1A1;
        mem[102] = 16'hA2A2; mem[103] = 16'hA3A3;
        cyc();
        launch(10'd100, 10'd4);
        for (int c = 1; c <= 8; c++) begin
            checks++;
            if (busy !== (c <= 6)) begin
                errors++; $display("FAIL basic_busy c=%0d got %b exp %b", c, busy, (c <= 6));
            end
            checks++;
            if (sample_valid !== (c >= 3 && c <= 6)) begin
                errors++; $display("FAIL basic_valid c=%0d got %b exp %b", c, sample_valid, (c >= 3 && c <= 6));
            end
            checks++;
            if (done !== (c == 7)) begin
                errors++; $display("FAIL basic_done c=%0d got %b exp %b", c, done, (c == 7));
            end
            checks++;
            if (prime_done !== 1'b0) begin
                errors++; $display("FAIL basic_prime c=%0d got %b exp 0", c, prime_done);
            end
            checks++;
            if (mem_rd !== (c <= 4)) begin
                errors++; $display("FAIL basic_rd c=%0d got %b exp %b", c, mem_rd, (c <= 4));
            end
            if (c <= 4) begin
                checks++;
                if (mem_addr !== AW'(99 + c)) begin
                    errors++; $display("FAIL basic_addr c=%0d got %0d exp %0d", c, mem_addr, 99 + c);
                end
            end
            cyc();
        end
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL basic_left got %0d pending exp 0", sb.size());
        end
    endtask

    task automatic test_zero_length();
        cyc();
        launch(10'd5, 10'd0);
        for (int c = 1; c <= 4; c++) begin
            checks++;
            if (done !== (c == 1)) begin
                errors++; $display("FAIL zero_done c=%0d got %b exp %b", c, done, (c == 1));
            end
            checks++;
            if ({busy, mem_rd, sample_valid} !== 3'b000) begin
                errors++; $display("FAIL zero_idle c=%0d got b=%b rd=%b v=%b exp 000", c, busy, mem_rd, sample_valid);
            end
            cyc();
        end
    endtask

    task automatic test_stall();
        int   n_xfer;
        logic prev_xf;
        logic done_seen;
        logic xf;
        n_xfer = 0; prev_xf = 1'b0; done_seen = 1'b0;
        for (int i = 0; i < 20; i++) mem[i] = 16'(i);
        cyc();
        launch(10'd0, 10'd20);
        for (int c = 1; c <= 80 && !done_seen; c++) begin
            stall = (c >= 5 && c <= 8);
            #1;
            if (c == 4 || c == 5) begin
                checks++;
                if (mem_rd !== (c == 4)) begin
                    errors++; $display("FAIL stall_rd c=%0d got %b exp %b", c, mem_rd, (c == 4));
                end
            end
            checks++;
            if (prime_done !== (n_xfer >= WIN)) begin
                errors++; $display("FAIL stall_prime c=%0d got %b exp %b", c, prime_done, (n_xfer >= WIN));
            end
            checks++;
            if (done !== (n_xfer == 20 && prev_xf)) begin
                errors++; $display("FAIL stall_done c=%0d got %b exp %b", c, done, (n_xfer == 20 && prev_xf));
            end
            if (done === 1'b1) done_seen = 1'b1;
            xf = (sample_valid === 1'b1) && !stall;
            if (xf) n_xfer++;
            prev_xf = xf;
            cyc();
        end
        stall = 1'b0;
        checks++;
        if (!done_seen || n_xfer != 20) begin
            errors++; $display("FAIL stall_end got done_seen=%b transfers=%0d exp 1 and 20", done_seen, n_xfer);
        end
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL stall_left got %0d pending exp 0", sb.size());
        end
    endtask

    task automatic test_wrap();
        logic [AW-1:0] addrs [$];
        logic [AW-1:0] exp_a [4];
        exp_a = '{10'd1022, 10'd1023, 10'd0, 10'd1};
        mem[1022] = 16'hE0E0; mem[1023] = 16'hE1E1;
        mem[0] = 16'hE2E2; mem[1] = 16'hE3E3;
        cyc();
        launch(10'd1022, 10'd4);
        for (int c = 1; c <= 10; c++) begin
            if (mem_rd === 1'b1) addrs.push_back(mem_addr);
            cyc();
        end
        checks++;
        if (addrs.size() != 4) begin
            errors++; $display("FAIL wrap_count got %0d exp 4", addrs.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (addrs[i] !== exp_a[i]) begin
                    errors++; $display("FAIL wrap_addr idx=%0d got %0d exp %0d", i, addrs[i], exp_a[i]);
                end
            end
        end
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL wrap_left got %0d pending exp 0", sb.size());
        end
    endtask

    task automatic test_reset_mid();
        cyc();
        launch(10'd200, 10'd20);
        repeat (5) cyc();
        reset = 1'b0;
        sb.delete();
        #1;
        checks++;
        if ({mem_rd, mem_addr, sample, sample_valid, prime_done, busy, done} !== '0) begin
            errors++;
            $display("FAIL midreset_outputs got rd=%b addr=%h s=%h v=%b p=%b b=%b d=%b exp all 0",
                     mem_rd, mem_addr, sample, sample_valid, prime_done, busy, done);
        end
        repeat (2) cyc();
        reset = 1'b1;
        for (int c = 0; c < 5; c++) begin
            cyc();
            checks++;
            if ({done, sample_valid, busy} !== 3'b000) begin
                errors++; $display("FAIL midreset_quiet c=%0d got d=%b v=%b b=%b exp 000", c, done, sample_valid, busy);
            end
        end
        launch(10'd400, 10'd3);
        for (int c = 1; c <= 6; c++) begin
            checks++;
            if (sample_valid !== (c >= 3 && c <= 5)) begin
                errors++; $display("FAIL midreset_valid c=%0d got %b exp %b", c, sample_valid, (c >= 3 && c <= 5));
            end
            checks++;
            if (done !== (c == 6)) begin
                errors++; $display("FAIL midreset_done c=%0d got %b exp %b", c, done, (c == 6));
            end
            cyc();
        end
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL midreset_left got %0d pending exp 0", sb.size());
        end
    endtask

    task automatic test_back_to_back();
        int done_c;
        done_c = 0;
        cyc();
        launch(10'd300, 10'd10);
        for (int c = 1; c <= 40 && done_c == 0; c++) begin
            if (c == 4) begin
                start = 1'b1; base_addr = 10'd500; length = 10'd5;
            end else begin
                start = 1'b0;
            end
            #1;
            if (c == 5) begin
                checks++;
                if (busy !== 1'b1) begin
                    errors++; $display("FAIL b2b_busy got %b exp 1", busy);
                end
            end
            if (done === 1'b1) done_c = c;
            else cyc();
        end
        checks++;
        if (done_c != 13) begin
            errors++; $display("FAIL b2b_done_cycle got %0d exp 13", done_c);
        end
        launch(10'd600, 10'd3);
        for (int c = 1; c <= 6; c++) begin
            checks++;
            if (busy !== (c <= 5)) begin
                errors++; $display("FAIL b2b2_busy c=%0d got %b exp %b", c, busy, (c <= 5));
            end
            checks++;
            if (done !== (c == 6)) begin
                errors++; $display("FAIL b2b2_done c=%0d got %b exp %b", c, done, (c == 6));
            end
            cyc();
        end
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL b2b_left got %0d pending exp 0", sb.size());
        end
    endtask

    task automatic test_win_length();
        cyc();
        launch(10'd50, 10'd12);
        for (int c = 1; c <= 16; c++) begin
            checks++;
            if (done !== (c == 15)) begin
                errors++; $display("FAIL win_done c=%0d got %b exp %b", c, done, (c == 15));
            end
            checks++;
            if (prime_done !== (c >= 15)) begin
                errors++; $display("FAIL win_prime c=%0d got %b exp %b", c, prime_done, (c >= 15));
            end
            cyc();
        end
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL win_left got %0d pending exp 0", sb.size());
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 16'(i * 37 + 5);
        test_reset();
        test_basic();
        test_zero_length();
        test_stall();
        test_wrap();
        test_reset_mid();
        test_back_to_back();
        test_win_length();
        repeat (2) cyc();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog expired");
    end

endmodule
